ps2_keycode_ctrl: RTL and testbench
===================================

Name: ps2_keycode_ctrl

Overview:
- Front-end controller for the keyboard datapath. Receives PS/2 frames and assembles the 32-bit keycode history register.
- The digit/key-release decoder reads keycode directly. Byte order: newest byte in [7:0], oldest in [31:24].
- Classifies make, break and extended bytes, and emits one-cycle key event strobes for the calculator logic.
- Sits between the board PS/2 pins and the keycode decoder.

Parameters:
- FILTER_LEN, 8: consecutive identical ps2_clk samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered falling edge mid-frame before the frame is aborted.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
- ps2_data  input  1  raw PS/2 data pin (asynchronous)
- keycode  output  32  byte history; shifts left by 8 on each good byte
- scancode  output  8  last non-prefix byte received
- byte_valid  output  1  one-cycle pulse per good frame
- key_press  output  1  one-cycle pulse, make code received
- key_release  output  1  one-cycle pulse, break code completed
- extended  output  1  1 when the current scancode was preceded by E0
- frame_err  output  1  one-cycle pulse on parity, stop or timeout error
- busy  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset values: keycode=0, scancode=0, all pulses=0, extended=0, busy=0, FSM=IDLE, internal flags cleared. Reset is asynchronous; asserting it mid-frame aborts the frame with no pulse.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchronizer.
- Clock filter: the filtered clock takes the synchronized level after FILTER_LEN equal consecutive samples. A fall_edge strobe is produced when the filtered clock goes 1->0.
- ps2_data is sampled only on fall_edge.
- FSM states and transitions:
  - IDLE: on fall_edge with data=0 (start bit) -> DATA, bit_cnt=0. A data=1 edge is ignored.
  - DATA: shift the data bit into the byte register LSB-first. After the 8th bit -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on fall_edge -> IDLE.
- Frame is good when the 8 data bits plus the parity bit have an odd count of ones AND the stop bit = 1.
- Good frame, in the cycle after the stop-bit fall_edge:
  - keycode <= {keycode[23:0], byte}
  - byte_valid=1
- Bad frame:
  - frame_err=1
  - keycode, scancode and the flags are unchanged.
- Timeout:
  - In DATA, PARITY or STOP, a cycle counter resets on each fall_edge.
  - When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE, frame_err pulses once, keycode unchanged.
  - In IDLE the counter is held at 0.
- Byte classification, same cycle as byte_valid:
  - E0: set ext_pending; no key pulse.
  - F0: set brk_pending; no key pulse.
  - Any other byte: scancode <= byte and extended <= ext_pending.
    - If brk_pending: key_release=1.
    - Else: key_press=1.
    - Then clear both pending flags.
- A frame_err leaves the pending flags intact. The next good byte completes the sequence.
- Simultaneous events: pulse outputs are never asserted together except byte_valid with key_press or key_release. frame_err and byte_valid are mutually exclusive.
- Latency: fall_edge is at most 2 + FILTER_LEN cycles after the raw pin edge. Outputs follow the stop-bit fall_edge by 1 cycle.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- When defined:
  - A held register {valid, ext, code} tracks the last pressed key.
  - key_press is suppressed when the make code and extended flag equal the held key (auto-repeat).
  - A release of the held key clears held.valid. key_release is never suppressed.
  - keycode, byte_valid and scancode are unaffected.
- When undefined: every make byte pulses key_press and there is no held register.

Test Plan:
- Bench settings: FILTER_LEN=4, TIMEOUT_CYCLES=2000, ps2_clk half-period 50 clk.
- Make 0x16 with parity 0, stop 1 -> byte_valid and key_press one cycle each; scancode=0x16; keycode=0x00000016; extended=0.
- Sequence 0x16, F0, 0x16 -> keycode=0x0016F016; a single key_release pulse on the last byte; no key_press on the F0 byte.
- E0, 0x75, E0, F0, 0x75 -> key_press with extended=1; then key_release with extended=1; keycode=0x75E0F075.
- Byte 0x1C with the parity bit flipped -> frame_err pulse; keycode unchanged; no key pulse. A following good 0x1C -> key_press.
- Stop ps2_clk after 5 data bits -> frame_err exactly 2000 cycles after the last edge; busy falls. The next full frame 0x45 is received correctly.
- 1-cycle ps2_clk glitches every 20 cycles during idle -> no fall_edge, busy stays 0.
- With PS2_TYPEMATIC_FILTER_EN: 0x1C, 0x1C, 0x1C, F0, 0x1C, 0x1C -> exactly 2 key_press pulses and 1 key_release pulse.

Source files
------------

// File: rtl/ps2_keycode_ctrl.sv
// PS/2 receiver: filtered clock, framing FSM, keycode history and key events.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make codes.
module ps2_keycode_ctrl #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [31:0] keycode,
   output logic [7:0]  scancode,
   output logic        byte_valid,
   output logic        key_press,
   output logic        key_release,
   output logic        extended,
   output logic        frame_err,
   output logic        busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;

   logic [1:0]            clk_sync;
   logic [1:0]            dat_sync;
   logic [FILTER_LEN-1:0] clk_hist;
   logic                  clk_filt;
   logic                  fall_edge;
   logic                  all_lo;
   logic                  all_hi;
   logic [TW-1:0]         to_cnt;
   logic [2:0]            bit_cnt;
   logic [7:0]            shreg;
   logic                  par_bit;
   logic                  tmo;
   logic                  stop_hit;
   logic                  frame_good;
   logic                  frame_bad;
   logic                  ext_pend;
   logic                  brk_pend;
   logic                  is_e0;
   logic                  is_f0;
`ifdef PS2_TYPEMATIC_FILTER_EN
   logic                  held_v;
   logic                  held_ext;
   logic [7:0]            held_code;
   logic                  held_hit;
`endif

   assign all_lo    = (clk_hist == '0);
   assign all_hi    = (&clk_hist);
   // fall_edge fires in the same cycle the filter window becomes all-low
   assign fall_edge = clk_filt & all_lo;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_hist <= '1;
         clk_filt <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
         if (all_lo) clk_filt <= 1'b0;
         else if (all_hi) clk_filt <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      tmo      = 1'b0;
      if (state != IDLE && !fall_edge &&
          to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         tmo      = 1'b1;
         state_nx = IDLE;
      end else if (fall_edge) begin
         case (state)
            IDLE:    if (!dat_sync[1]) state_nx = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
            PARITY:  state_nx = STOP;
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   assign stop_hit   = fall_edge && (state == STOP);
   assign frame_good = stop_hit && dat_sync[1] && (^{shreg, par_bit});
   assign frame_bad  = stop_hit && !frame_good;
   assign is_e0      = (shreg == 8'hE0);
   assign is_f0      = (shreg == 8'hF0);
`ifdef PS2_TYPEMATIC_FILTER_EN
   assign held_hit   = held_v && held_code == shreg && held_ext == ext_pend;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt      <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         par_bit     <= 1'b0;
      end else begin
         if (state == IDLE || fall_edge) to_cnt <= '0;
         else                            to_cnt <= to_cnt + 1'b1;
         if (fall_edge) begin
            case (state)
               IDLE: bit_cnt <= '0;
               DATA: begin
                  shreg   <= {dat_sync[1], shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY:  par_bit <= dat_sync[1];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keycode     <= '0;
         scancode    <= '0;
         extended    <= 1'b0;
         byte_valid  <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         frame_err   <= 1'b0;
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
         held_v      <= 1'b0;
         held_ext    <= 1'b0;
         held_code   <= '0;
`endif
      end else begin
         byte_valid  <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         frame_err   <= tmo | frame_bad;
         if (frame_good) begin
            byte_valid <= 1'b1;
            keycode    <= {keycode[23:0], shreg};
            unique case (1'b1)
               is_e0: ext_pend <= 1'b1;
               is_f0: brk_pend <= 1'b1;
               default: begin
                  scancode <= shreg;
                  extended <= ext_pend;
                  ext_pend <= 1'b0;
                  brk_pend <= 1'b0;
                  if (brk_pend) begin
                     key_release <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                     if (held_hit) held_v <= 1'b0;
`endif
                  end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                     key_press <= !held_hit;
                     held_v    <= 1'b1;
                     held_ext  <= ext_pend;
                     held_code <= shreg;
`else
                     key_press <= 1'b1;
`endif
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ps2_keycode_ctrl.sv
// Self-checking bench for ps2_keycode_ctrl: vector table, corner cases, random.
`timescale 1ns/1ps
module tb_ps2_keycode_ctrl;
   localparam int FL = 4;
   localparam int TO = 2000;
   localparam int HP = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [31:0] keycode;
   logic [7:0]  scancode;
   logic        byte_valid, key_press, key_release;
   logic        extended, frame_err, busy;

   always #5 clk = ~clk;

   ps2_keycode_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .scancode(scancode), .byte_valid(byte_valid),
      .key_press(key_press), .key_release(key_release),
      .extended(extended), .frame_err(frame_err), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0, c_bv = 0, c_kp = 0, c_kr = 0, c_fe = 0;
   int c_busy = 0, viol = 0, fe_cyc = 0;
   int t_fall = 0;

   always @(negedge clk) begin
      cyc++;
      if (byte_valid)  c_bv++;
      if (key_press)   c_kp++;
      if (key_release) c_kr++;
      if (busy)        c_busy++;
      if (frame_err) begin
         c_fe++;
         fe_cyc = cyc;
      end
      if ((frame_err && (byte_valid || key_press || key_release)) ||
          (key_press && key_release) ||
          ((key_press || key_release) && !byte_valid))
         viol++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // reference model state
   logic [31:0] m_kc = '0;
   logic [7:0]  m_sc = '0;
   logic        m_ext = 0, p_ext = 0, p_brk = 0;
   logic        h_v = 0, h_ext = 0;
   logic [7:0]  h_code = '0;
   logic        e_bv, e_kp, e_kr, e_fe;

   task automatic model_reset();
      m_kc = '0; m_sc = '0; m_ext = 0; p_ext = 0; p_brk = 0;
      h_v = 0; h_ext = 0; h_code = '0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit good);
      e_bv = 0; e_kp = 0; e_kr = 0; e_fe = !good;
      if (good) begin
         e_bv = 1;
         m_kc = {m_kc[23:0], b};
         if (b == 8'hE0) p_ext = 1;
         else if (b == 8'hF0) p_brk = 1;
         else begin
            m_sc  = b;
            m_ext = p_ext;
            if (p_brk) begin
               e_kr = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
               if (h_v && h_code == b && h_ext == p_ext) h_v = 0;
`endif
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
               e_kp   = !(h_v && h_code == b && h_ext == p_ext);
               h_v    = 1;
               h_code = b;
               h_ext  = p_ext;
`else
               e_kp = 1;
`endif
            end
            p_ext = 0;
            p_brk = 0;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b,
                                            input bit bp, input bit bs);
      return {~bs, (~^b) ^ bp, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         step(HP / 2);
         ps2_clk = 1'b0;
         t_fall  = cyc;
         step(HP);
         ps2_clk = 1'b1;
         step(HP / 2);
      end
      ps2_data = 1'b1;
   endtask

   task automatic xfer(input logic [7:0] b, input bit bp, input bit bs,
                       output int dbv, output int dkp,
                       output int dkr, output int dfe);
      int s_bv, s_kp, s_kr, s_fe;
      s_bv = c_bv; s_kp = c_kp; s_kr = c_kr; s_fe = c_fe;
      send_bits(mk_frame(b, bp, bs), 11);
      step(20);
      dbv = c_bv - s_bv; dkp = c_kp - s_kp;
      dkr = c_kr - s_kr; dfe = c_fe - s_fe;
   endtask

   task automatic run_model(input string tag, input logic [7:0] b,
                            input bit bad, output int dkp, output int dkr);
      int dbv, dfe;
      xfer(b, bad, 1'b0, dbv, dkp, dkr, dfe);
      model_frame(b, !bad);
      chk({tag, " byte_valid"}, dbv, e_bv);
      chk({tag, " key_press"}, dkp, e_kp);
      chk({tag, " key_release"}, dkr, e_kr);
      chk({tag, " frame_err"}, dfe, e_fe);
      chk({tag, " keycode"}, keycode, m_kc);
      chk({tag, " scancode"}, scancode, m_sc);
      chk({tag, " extended"}, extended, m_ext);
      chk({tag, " busy"}, busy, 0);
   endtask

   typedef struct {
      logic [7:0]  b;
      bit          bp;
      bit          bs;
      logic [31:0] kc;
      logic [7:0]  sc;
      bit          ext;
      bit          kp;
      bit          kr;
      bit          fe;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int dbv, dkp, dkr, dfe, s_fe, s_bv, s_busy, w, lat;
      int sum_kp, sum_kr, exp_kp, exp_kr;
      logic [7:0] rb;
      bit rbad;

      tbl[0]  = '{8'h16, 0, 0, 32'h00000016, 8'h16, 0, 1, 0, 0};
      tbl[1]  = '{8'hF0, 0, 0, 32'h000016F0, 8'h16, 0, 0, 0, 0};
      tbl[2]  = '{8'h16, 0, 0, 32'h0016F016, 8'h16, 0, 0, 1, 0};
      tbl[3]  = '{8'hE0, 0, 0, 32'h16F016E0, 8'h16, 0, 0, 0, 0};
      tbl[4]  = '{8'h75, 0, 0, 32'hF016E075, 8'h75, 1, 1, 0, 0};
      tbl[5]  = '{8'hE0, 0, 0, 32'h16E075E0, 8'h75, 1, 0, 0, 0};
      tbl[6]  = '{8'hF0, 0, 0, 32'hE075E0F0, 8'h75, 1, 0, 0, 0};
      tbl[7]  = '{8'h75, 0, 0, 32'h75E0F075, 8'h75, 1, 0, 1, 0};
      tbl[8]  = '{8'h1C, 1, 0, 32'h75E0F075, 8'h75, 1, 0, 0, 1};
      tbl[9]  = '{8'h1C, 0, 0, 32'hE0F0751C, 8'h1C, 0, 1, 0, 0};
      tbl[10] = '{8'h2A, 0, 1, 32'hE0F0751C, 8'h1C, 0, 0, 0, 1};

      step(5);
      chk("reset keycode", keycode, 0);
      chk("reset scancode", scancode, 0);
      chk("reset pulses",
          {byte_valid, key_press, key_release, frame_err}, 0);
      chk("reset extended", extended, 0);
      chk("reset busy", busy, 0);
      reset = 1'b0;
      step(5);

      for (int i = 0; i < 11; i++) begin
         xfer(tbl[i].b, tbl[i].bp, tbl[i].bs, dbv, dkp, dkr, dfe);
         model_frame(tbl[i].b, !(tbl[i].bp || tbl[i].bs));
         chk($sformatf("vec%0d keycode", i), keycode, tbl[i].kc);
         chk($sformatf("vec%0d scancode", i), scancode, tbl[i].sc);
         chk($sformatf("vec%0d extended", i), extended, tbl[i].ext);
         chk($sformatf("vec%0d byte_valid", i), dbv,
             !(tbl[i].bp || tbl[i].bs));
         chk($sformatf("vec%0d key_press", i), dkp, tbl[i].kp);
         chk($sformatf("vec%0d key_release", i), dkr, tbl[i].kr);
         chk($sformatf("vec%0d frame_err", i), dfe, tbl[i].fe);
         step(30);
      end

      // timeout: stop clocking after start + 5 data bits
      s_fe = c_fe;
      s_bv = c_bv;
      send_bits(mk_frame(8'h33, 0, 0), 6);
      chk("timeout busy mid", busy, 1);
      w = 0;
      while (c_fe == s_fe && w < 3 * TO) begin
         step(1);
         w++;
      end
      chk("timeout fired", c_fe - s_fe, 1);
      lat = fe_cyc - t_fall;
      n_cmp++;
      if (lat < TO || lat > TO + FL + 8) begin
         n_bad++;
         $display("FAIL timeout latency: got %0d expected %0d..%0d",
                  lat, TO, TO + FL + 8);
      end
      step(1);
      chk("timeout busy low", busy, 0);
      chk("timeout keycode", keycode, m_kc);
      chk("timeout no byte", c_bv - s_bv, 0);
      step(30);
      run_model("after timeout 45", 8'h45, 0, dkp, dkr);

      // short ps2_clk glitches while idle
      s_fe = c_fe;
      s_bv = c_bv;
      s_busy = c_busy;
      repeat (10) begin
         step(19);
         ps2_clk = 1'b0;
         step(1);
         ps2_clk = 1'b1;
      end
      step(10);
      chk("glitch busy", c_busy - s_busy, 0);
      chk("glitch byte", c_bv - s_bv, 0);
      chk("glitch err", c_fe - s_fe, 0);

      // reset mid-frame
      s_fe = c_fe;
      s_bv = c_bv;
      send_bits(mk_frame(8'h5A, 0, 0), 3);
      chk("midreset busy before", busy, 1);
      reset = 1'b1;
      step(2);
      chk("midreset busy", busy, 0);
      chk("midreset keycode", keycode, 0);
      chk("midreset scancode", scancode, 0);
      chk("midreset extended", extended, 0);
      reset = 1'b0;
      model_reset();
      step(20);
      chk("midreset no err", c_fe - s_fe, 0);
      chk("midreset no byte", c_bv - s_bv, 0);

      // typematic sequence
      sum_kp = 0; sum_kr = 0; exp_kp = 0; exp_kr = 0;
      foreach (tbl[i]) if (i < 6) begin
         rb = (i == 3) ? 8'hF0 : 8'h1C;
         run_model($sformatf("typ%0d", i), rb, 0, dkp, dkr);
         sum_kp += dkp; sum_kr += dkr;
         exp_kp += e_kp; exp_kr += e_kr;
         step(30);
      end
      chk("typ press model", sum_kp, exp_kp);
      chk("typ release model", sum_kr, exp_kr);
`ifdef PS2_TYPEMATIC_FILTER_EN
      chk("typ press total", sum_kp, 2);
`else
      chk("typ press total", sum_kp, 4);
`endif
      chk("typ release total", sum_kr, 1);

      // random traffic
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    rb = 8'hE0;
            2, 3:    rb = 8'hF0;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         rbad = ($urandom_range(0, 7) == 0);
         run_model($sformatf("rnd%0d", i), rb, rbad, dkp, dkr);
         step(10);
      end

      chk("pulse exclusivity", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
